// File: rtl/half_buffer.sv
// half_buffer: single-entry AXI-Stream register slice.
// Holds at most one beat. Every output is driven straight from a flop, so
// there is no combinational path between the two handshake sides. Peak
// throughput is one beat every two cycles.
module half_buffer #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] data_q;

    // Two-state slice: capture a beat while empty, release it while full.
    // s_tready/m_tvalid are registered copies of the state, so neither
    // depends on the opposite side's handshake input.
    // NOTE: all state here uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= EMPTY;
            s_tready <= 1'b1;
            m_tvalid <= 1'b0;
            // NOTE: the payload register is reset too, so m_tdata reads 0
            // after reset rather than whatever was last held.
            data_q   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (s_tvalid) begin
                        data_q   <= s_tdata;
                        state    <= FULL;
                        s_tready <= 1'b0;
                        m_tvalid <= 1'b1;
                    end
                end
                FULL: begin
                    // data_q is left untouched so m_tdata stays stable
                    if (m_tready) begin
                        state    <= EMPTY;
                        s_tready <= 1'b1;
                        m_tvalid <= 1'b0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    s_tready <= 1'b1;
                    m_tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign m_tdata = data_q;

endmodule

// File: tb/tb_half_buffer.sv
// Directed and random-stall tests for half_buffer (DW=32 and DW=18 instances).
module tb_half_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;

    logic [17:0] s_tdata18 = '0;
    logic        s_tvalid18 = 1'b0;
    logic        s_tready18;
    logic [17:0] m_tdata18;
    logic        m_tvalid18;
    logic        m_tready18 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    half_buffer #(.DW(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    half_buffer #(.DW(18)) dut18 (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tdata  (s_tdata18),
        .s_tvalid (s_tvalid18),
        .s_tready (s_tready18),
        .m_tdata  (m_tdata18),
        .m_tvalid (m_tvalid18),
        .m_tready (m_tready18)
    );

    // Advance one rising edge and settle; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string name, input logic ev, input logic [31:0] ed,
                               input logic er);
        checks++;
        if (m_tvalid !== ev || m_tdata !== ed || s_tready !== er) begin
            errors++;
            $display("FAIL %s: got m_tvalid=%b m_tdata=%h s_tready=%b, want m_tvalid=%b m_tdata=%h s_tready=%b",
                     name, m_tvalid, m_tdata, s_tready, ev, ed, er);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEADBEEF;
        m_tready = 1'b0;
        step();
        step();
        expect_outs("reset_held", 1'b0, 32'h0, 1'b1);
        s_tvalid = 1'b0;
        reset_n  = 1'b1;
        step();
        expect_outs("reset_release", 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_single_beat();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 32'h12345678;
        step();
        s_tvalid = 1'b0;
        s_tdata  = 32'h0;
        expect_outs("single_valid", 1'b1, 32'h12345678, 1'b0);
        step();
        expect_outs("single_drained", 1'b0, 32'h12345678, 1'b1);
        step();
        expect_outs("single_idle", 1'b0, 32'h12345678, 1'b1);
    endtask

    task automatic test_backpressure();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hA5A5A5A5;
        step();
        for (int i = 0; i < 10; i++) begin
            s_tdata  = 32'h1000_0000 + i;
            s_tvalid = i[0];
            step();
            expect_outs($sformatf("bp_hold_%0d", i), 1'b1, 32'hA5A5A5A5, 1'b0);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        step();
        expect_outs("bp_drain", 1'b0, 32'hA5A5A5A5, 1'b1);
    endtask

    task automatic test_streaming();
        int in_idx  = 0;
        int out_idx = 0;
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        for (int cyc = 0; cyc < 32; cyc++) begin
            if (s_tready) begin
                if (in_idx < 16) begin
                    s_tdata = 32'(in_idx);
                    in_idx++;
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            if (m_tvalid) begin
                checks++;
                if (m_tdata !== 32'(out_idx)) begin
                    errors++;
                    $display("FAIL stream_data: got %h, want %h", m_tdata, 32'(out_idx));
                end
                out_idx++;
            end
            step();
        end
        s_tvalid = 1'b0;
        checks++;
        if (in_idx != 16 || out_idx != 16 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL stream_count: got in=%0d out=%0d m_tvalid=%b, want in=16 out=16 m_tvalid=0",
                     in_idx, out_idx, m_tvalid);
        end
    endtask

    task automatic test_random_stall();
        logic [31:0] q[$];
        logic [31:0] want;
        int          excl_err = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            if (s_tready && m_tvalid) excl_err++;
            if (s_tvalid && s_tready) q.push_back(s_tdata);
            if (m_tvalid && m_tready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got beat %h, want no beat", m_tdata);
                end else begin
                    want = q.pop_front();
                    if (m_tdata !== want) begin
                        errors++;
                        $display("FAIL rand_data: got %h, want %h", m_tdata, want);
                    end
                end
            end
            step();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (m_tvalid) begin
                checks++;
                want = (q.size() != 0) ? q.pop_front() : 32'hX;
                if (m_tdata !== want) begin
                    errors++;
                    $display("FAIL rand_tail: got %h, want %h", m_tdata, want);
                end
            end
            step();
        end
        checks++;
        if (q.size() != 0 || excl_err != 0) begin
            errors++;
            $display("FAIL rand_final: got lost=%0d overlap=%0d, want lost=0 overlap=0",
                     q.size(), excl_err);
        end
    endtask

    task automatic test_mid_reset();
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'h5555AAAA;
        step();
        s_tvalid = 1'b0;
        expect_outs("mid_held", 1'b1, 32'h5555AAAA, 1'b0);
        reset_n  = 1'b0;
        m_tready = 1'b1;
        step();
        reset_n = 1'b1;
        expect_outs("mid_after_reset", 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_outs($sformatf("mid_no_deliver_%0d", i), 1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_width();
        logic [17:0] vals[2];
        vals[0] = 18'h3FFFF;
        vals[1] = 18'h2AAAA;
        m_tready18 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid18 = 1'b1;
            s_tdata18  = vals[i];
            step();
            s_tvalid18 = 1'b0;
            s_tdata18  = '0;
            checks++;
            if (m_tvalid18 !== 1'b1 || m_tdata18 !== vals[i] || s_tready18 !== 1'b0) begin
                errors++;
                $display("FAIL width18_%0d: got v=%b d=%h r=%b, want v=1 d=%h r=0",
                         i, m_tvalid18, m_tdata18, s_tready18, vals[i]);
            end
            m_tready18 = 1'b1;
            step();
            m_tready18 = 1'b0;
            checks++;
            if (m_tvalid18 !== 1'b0 || s_tready18 !== 1'b1) begin
                errors++;
                $display("FAIL width18_drain_%0d: got v=%b r=%b, want v=0 r=1",
                         i, m_tvalid18, s_tready18);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_streaming();
        test_random_stall();
        test_mid_reset();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
